// File: rtl/rtype_pkg.sv
// Shared types and encodings for the R-type issue controller.
// Optional feature macro: LOAD_UPPER_EN (lui support).
package rtype_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    EXE,
    WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/rtype_decode.sv
// Combinational decode of one instruction word into fields and legality.
// LOAD_UPPER_EN makes op 0x0F (lui) a legal instruction.
module rtype_decode
  import rtype_pkg::*;
#(
  parameter int AW = 5,
  parameter int CW = 3
) (
  input  logic [31:0]   instr,
  output logic [AW-1:0] rs,
  output logic [AW-1:0] rt,
  output logic [AW-1:0] rd,
  output logic [CW-1:0] alu_ctrl,
  output logic          is_lui,
  output logic          legal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_shamt;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  // shift amount has no meaning for the supported ops
  assign unused_shamt = ^instr[10:6];

  // map opcode/funct to an ALU operation and legality flag
  always_comb begin
    alu_ctrl = '0;
    is_lui   = 1'b0;
    legal    = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        case (funct)
          FUNCT_ADD: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
          FUNCT_SUB: begin alu_ctrl = ALU_SUB; legal = 1'b1; end
          FUNCT_AND: begin alu_ctrl = ALU_AND; legal = 1'b1; end
          FUNCT_OR:  begin alu_ctrl = ALU_OR;  legal = 1'b1; end
          FUNCT_SLT: begin alu_ctrl = ALU_SLT; legal = 1'b1; end
          default:   ;
        endcase
      end
`ifdef LOAD_UPPER_EN
      (op == OP_LUI): begin
        is_lui = 1'b1;
        legal  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/rtype_issue_ctrl.sv
// Issue/writeback controller driving a regfile+ALU processing unit.
// LOAD_UPPER_EN (in rtype_decode) enables the two-cycle lui path.
module rtype_issue_ctrl
  import rtype_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [AW-1:0] readreg1,
  output logic [AW-1:0] readreg2,
  output logic [AW-1:0] writereg,
  output logic [CW-1:0] alu_ctrl,
  output logic          regwrite,
  output logic [DW-1:0] data,
  input  logic [DW-1:0] result,
  output logic          illegal,
  output logic          illegal_seen
);

  state_t        state;
  logic [AW-1:0] rd_q;
  logic [15:0]   imm_q;
  logic          lui_q;
  logic          legal_q;

  logic [AW-1:0] dec_rs;
  logic [AW-1:0] dec_rt;
  logic [AW-1:0] dec_rd;
  logic [CW-1:0] dec_alu;
  logic          dec_lui;
  logic          dec_legal;
  logic          accept;

  assign accept = instr_valid && instr_ready;

  rtype_decode #(
    .AW(AW),
    .CW(CW)
  ) u_decode (
    .instr    (instr),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .rd       (dec_rd),
    .alu_ctrl (dec_alu),
    .is_lui   (dec_lui),
    .legal    (dec_legal)
  );

  // single-issue FSM with all outputs registered
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      instr_ready  <= 1'b0;
      readreg1     <= '0;
      readreg2     <= '0;
      writereg     <= '0;
      alu_ctrl     <= '0;
      regwrite     <= 1'b0;
      data         <= '0;
      illegal      <= 1'b0;
      illegal_seen <= 1'b0;
      rd_q         <= '0;
      imm_q        <= '0;
      lui_q        <= 1'b0;
      legal_q      <= 1'b0;
    end else begin
      regwrite <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= DEC;
            instr_ready <= 1'b0;
            readreg1    <= dec_rs;
            readreg2    <= dec_rt;
            alu_ctrl    <= dec_alu;
            rd_q        <= dec_rd;
            imm_q       <= instr[15:0];
            lui_q       <= dec_lui;
            legal_q     <= dec_legal;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        DEC: begin
          if (!legal_q) begin
            illegal      <= 1'b1;
            illegal_seen <= 1'b1;
            instr_ready  <= 1'b1;
            state        <= IDLE;
          end else if (lui_q) begin
            data     <= {imm_q, {(DW-16){1'b0}}};
            writereg <= readreg2;
            regwrite <= 1'b1;
            state    <= WB;
          end else begin
            state <= EXE;
          end
        end
        EXE: begin
          data     <= result;
          writereg <= rd_q;
          regwrite <= 1'b1;
          state    <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Self-checking bench for rtype_issue_ctrl with a regfile/ALU model.
// Define LOAD_UPPER_EN for both bench and RTL to check the lui path.
module tb_rtype_issue_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  readreg1;
  logic [4:0]  readreg2;
  logic [4:0]  writereg;
  logic [2:0]  alu_ctrl;
  logic        regwrite;
  logic [31:0] data;
  logic [31:0] result;
  logic        illegal;
  logic        illegal_seen;

  int checks   = 0;
  int failures = 0;
  bit seen     = 0;

`ifdef LOAD_UPPER_EN
  localparam bit LUI_EN = 1'b1;
`else
  localparam bit LUI_EN = 1'b0;
`endif

  logic [31:0] pu_regs [32];

  always #5 clk = ~clk;

  rtype_issue_ctrl dut (
    .clk          (clk),
    .clr          (clr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .readreg1     (readreg1),
    .readreg2     (readreg2),
    .writereg     (writereg),
    .alu_ctrl     (alu_ctrl),
    .regwrite     (regwrite),
    .data         (data),
    .result       (result),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  // processing unit: ALU on current read ports
  always_comb begin
    logic [31:0] a;
    logic [31:0] b;
    a = pu_regs[readreg1];
    b = pu_regs[readreg2];
    result = 32'h0;
    case (alu_ctrl)
      3'b010:  result = a + b;
      3'b110:  result = a - b;
      3'b000:  result = a & b;
      3'b001:  result = a | b;
      3'b111:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'h0;
    endcase
  end

  // processing unit: regfile write
  always @(posedge clk) begin
    if (regwrite) pu_regs[writereg] <= data;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // expected behaviour of one instruction from the ISA rules
  task automatic ref_model(input logic [31:0] w, output int lat,
                           output logic [4:0] wr, output logic [31:0] d,
                           output logic ill, output logic [2:0] alu);
    logic [31:0] a;
    logic [31:0] b;
    a   = pu_regs[w[25:21]];
    b   = pu_regs[w[20:16]];
    ill = 1'b0;
    lat = 3;
    wr  = w[15:11];
    d   = 32'h0;
    alu = 3'b000;
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20: begin d = a + b; alu = 3'b010; end
        6'h22: begin d = a - b; alu = 3'b110; end
        6'h24: begin d = a & b; alu = 3'b000; end
        6'h25: begin d = a | b; alu = 3'b001; end
        6'h2A: begin
          d   = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          alu = 3'b111;
        end
        default: ill = 1'b1;
      endcase
    end else if (w[31:26] == 6'h0F && LUI_EN) begin
      lat = 2;
      wr  = w[20:16];
      d   = {w[15:0], 16'h0};
    end else begin
      ill = 1'b1;
    end
    if (ill) lat = 1;
  endtask

  task automatic issue(input logic [31:0] w, input bit hold);
    int          lat;
    int          n;
    logic [4:0]  wr;
    logic [31:0] d;
    logic        ill;
    logic [2:0]  alu;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_pre", instr_ready, 1);
    ref_model(w, lat, wr, d, ill, alu);
    instr_valid = 1'b1;
    instr       = w;
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (!hold || k == lat + 1) instr_valid = 1'b0;
      check("regwrite", regwrite, 32'(!ill && k == lat));
      check("illegal", illegal, 32'(ill && k == lat + 1));
      check("ready", instr_ready, 32'(k == lat + 1));
      if (k == 1) begin
        check("readreg1", readreg1, w[25:21]);
        check("readreg2", readreg2, w[20:16]);
        if (!ill && w[31:26] == 6'h00) check("alu_ctrl", alu_ctrl, alu);
      end
      if (!ill && k == lat) begin
        check("writereg", writereg, wr);
        check("data", data, d);
      end
    end
    if (ill) seen = 1'b1;
    check("illegal_seen", illegal_seen, seen);
  endtask

  task automatic clr_mid_exe(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_regwrite", regwrite, 0);
    check("clr_ready", instr_ready, 0);
    check("clr_data", data, 0);
    @(negedge clk);
    clr  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_clr_regwrite", regwrite, 0);
      check("post_clr_ready", instr_ready, 1);
    end
    check("post_clr_seen", illegal_seen, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  fl [5];
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24;
    fl[3] = 6'h25; fl[4] = 6'h2A;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: begin
        w[31:26] = 6'h00;
        w[5:0]   = fl[$urandom_range(0, 4)];
      end
      6:       w[31:26] = 6'h0F;
      7:       w[31:26] = 6'(($urandom_range(1, 63)));
      8:       w[31:26] = 6'h00;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) pu_regs[i] <= $urandom;
    pu_regs[1] <= 32'd3;
    pu_regs[2] <= 32'd4;
    clr         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 0);
    check("rst_regwrite", regwrite, 0);
    clr = 1'b0;
    @(negedge clk);
    check("init_ready", instr_ready, 1);
    check("init_regwrite", regwrite, 0);
    check("init_data", data, 0);
    check("init_seen", illegal_seen, 0);
    check("init_illegal", illegal, 0);

    issue(32'h0022_1820, 1'b0);
    check("add_data7", data, 32'h7);
    issue(32'h0043_2022, 1'b1);
    issue(32'h0022_183F, 1'b0);
    clr_mid_exe(32'h0022_1824);
    issue(32'h3C05_BEEF, 1'b0);
    issue(32'h0022_1820, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(rand_instr(), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
